tt_sweeper: RTL and testbench



---
 rtl/tt_sweeper_pkg.sv | 13 +
 rtl/misr16.sv | 37 +++
 rtl/tt_sweeper.sv | 93 +++++++++
 tb/tb_tt_sweeper.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encodings and MISR constants.
package tt_sweeper_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  localparam logic [15:0] MISR_SEED = 16'hFFFF;
  // Feedback taps 16,14,13,11 -> register bits 15,13,12,10.
  localparam logic [15:0] MISR_TAPS = 16'hB400;

endpackage

// File: rtl/misr16.sv
// 16-bit MISR: clr reloads the seed, en folds one response word into the signature.
module misr16
  import tt_sweeper_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;
  logic        fb;

  always_comb begin
    fb    = ^(sig_q & MISR_TAPS);
    sig_d = sig_q;
    if (clr) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = {sig_q[14:0], fb} ^ din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/tt_sweeper.sv
// Exhaustive truth-table sweeper: steps dut_in through all 2^N values, holds each
// for SETTLE cycles, and captures dut_out into table_out and a MISR signature.
module tt_sweeper
  import tt_sweeper_pkg::*;
#(
  parameter int N      = 4,
  parameter int M      = 1,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N-1:0]         dut_in,
  input  logic [M-1:0]         dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [(2**N)*M-1:0]  table_out,
  output logic [15:0]          signature
);

  localparam int          TW       = (2**N) * M;
  localparam logic [7:0]  CNT_LAST = 8'(SETTLE - 1);
  localparam logic [N-1:0] VEC_ONE = N'(1);
  localparam logic [N-1:0] VEC_MAX = '1;

  state_e        state_q;
  logic [N-1:0]  vec_q;
  logic [7:0]    cnt_q;
  logic [TW-1:0] table_q;
  logic          done_q;

  logic          accept;
  logic          capture;
  logic [15:0]   misr_din;

  // start is only honoured in IDLE; a sweep cannot be restarted or aborted.
  assign accept   = (state_q == ST_IDLE) && start;
  assign capture  = (state_q == ST_SWEEP) && (cnt_q == CNT_LAST);
  assign misr_din = 16'(dut_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            vec_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            state_q <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= '0;
            table_q[int'(vec_q) * M +: M] <= dut_out;
            // The last vector stays on dut_in after completion; no wrap to 0.
            if (vec_q == VEC_MAX) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              vec_q <= vec_q + VEC_ONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  misr16 u_misr (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (capture),
    .din (misr_din),
    .sig (signature)
  );

  assign dut_in    = vec_q;
  assign busy      = (state_q == ST_SWEEP);
  assign done      = done_q;
  assign table_out = table_q;

endmodule

// File: tb/tb_tt_sweeper.sv
// Directed bench for tt_sweeper: an N=4/M=1/SETTLE=2 instance and an
// N=3/M=2/SETTLE=1 instance sharing clock and reset.
module tb_tt_sweeper;

  logic        clk;
  logic        rst;

  logic        start4;
  logic [3:0]  dut_in4;
  logic [0:0]  dut_out4;
  logic        busy4;
  logic        done4;
  logic [15:0] table4;
  logic [15:0] sig4;
  logic        and_mode;

  logic        start3;
  logic [2:0]  dut_in3;
  logic [1:0]  dut_out3;
  logic        busy3;
  logic        done3;
  logic [15:0] table3;
  logic [15:0] sig3;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational blocks under test.
  assign dut_out4 = and_mode ? (&dut_in4) : (^dut_in4);
  assign dut_out3 = dut_in3[1:0];

  tt_sweeper #(.N(4), .M(1), .SETTLE(2)) u4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .dut_in    (dut_in4),
    .dut_out   (dut_out4),
    .busy      (busy4),
    .done      (done4),
    .table_out (table4),
    .signature (sig4)
  );

  tt_sweeper #(.N(3), .M(2), .SETTLE(1)) u3 (
    .clk       (clk),
    .rst       (rst),
    .start     (start3),
    .dut_in    (dut_in3),
    .dut_out   (dut_out3),
    .busy      (busy3),
    .done      (done3),
    .table_out (table3),
    .signature (sig3)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ d;
  endfunction

  // fn 0: XOR of 4-bit input, fn 1: AND of 4-bit input, fn 2: low 2 bits of 3-bit input
  function automatic logic [15:0] sig_model(input int fn);
    logic [15:0] s;
    logic [3:0]  kv;
    logic [15:0] d;
    int          depth;
    s     = 16'hFFFF;
    depth = (fn == 2) ? 8 : 16;
    for (int k = 0; k < depth; k++) begin
      kv = k[3:0];
      if (fn == 0)      d = {15'd0, ^kv};
      else if (fn == 1) d = {15'd0, &kv};
      else              d = {14'd0, kv[1:0]};
      s = misr_step(s, d);
    end
    return s;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts edges until the selected done is seen; bounded by limit.
  task automatic wait_done(input bit sel3, input int limit, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!(sel3 ? done3 : done4) && edges < limit);
  endtask

  task automatic check_reset4(input string tag);
    check({tag, "_dut_in"}, 32'(dut_in4), 32'd0);
    check({tag, "_busy"},   32'(busy4),   32'd0);
    check({tag, "_done"},   32'(done4),   32'd0);
    check({tag, "_table"},  32'(table4),  32'd0);
    check({tag, "_sig"},    32'(sig4),    32'hFFFF);
  endtask

  task automatic pulse_start4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int edges;
    int done_seen;
    logic [15:0] exp_xor_sig;
    logic [15:0] exp_and_sig;
    logic [15:0] exp_u3_sig;

    exp_xor_sig = sig_model(0);
    exp_and_sig = sig_model(1);
    exp_u3_sig  = sig_model(2);

    rst      = 1'b1;
    start4   = 1'b0;
    start3   = 1'b0;
    and_mode = 1'b0;
    tick();
    tick();
    check_reset4("reset");
    check("reset_u3_sig", 32'(sig3), 32'hFFFF);
    rst = 1'b0;
    tick();

    // XOR sweep: done exactly 32 edges after the start edge.
    pulse_start4();
    check("xor_busy_after_start", 32'(busy4), 32'd1);
    wait_done(1'b0, 100, edges);
    check("xor_done_latency", 32'(edges), 32'd32);
    check("xor_table", 32'(table4), 32'h6996);
    check("xor_sig", 32'(sig4), 32'(exp_xor_sig));
    check("xor_busy_at_done", 32'(busy4), 32'd0);
    tick();
    check("xor_done_one_cycle", 32'(done4), 32'd0);
    check("xor_table_hold", 32'(table4), 32'h6996);

    // AND sweep with per-cycle vector timing.
    and_mode = 1'b1;
    pulse_start4();
    check("and_vec_j0", 32'(dut_in4), 32'd0);
    for (int j = 1; j <= 32; j++) begin
      tick();
      if (j < 32) begin
        check($sformatf("and_vec_j%0d", j), 32'(dut_in4), 32'(j / 2));
        check($sformatf("and_nodone_j%0d", j), 32'(done4), 32'd0);
      end else begin
        check("and_done_at_32", 32'(done4), 32'd1);
      end
    end
    check("and_table", 32'(table4), 32'h8000);
    check("and_sig", 32'(sig4), 32'(exp_and_sig));
    tick();
    check("and_vec_hold", 32'(dut_in4), 32'd15);

    // N=3, M=2, SETTLE=1.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("u3_busy", 32'(busy3), 32'd1);
    wait_done(1'b1, 50, edges);
    check("u3_done_latency", 32'(edges), 32'd8);
    check("u3_table", 32'(table3), 32'hE4E4);
    check("u3_sig", 32'(sig3), 32'(exp_u3_sig));

    // Start pulsed mid-sweep at vector 5 is ignored.
    and_mode = 1'b0;
    pulse_start4();
    for (int j = 1; j <= 10; j++) tick();
    check("midstart_vec5", 32'(dut_in4), 32'd5);
    pulse_start4();
    check("midstart_vec_after", 32'(dut_in4), 32'd5);
    wait_done(1'b0, 100, edges);
    check("midstart_latency", 32'(edges + 11), 32'd32);
    check("midstart_table", 32'(table4), 32'h6996);
    check("midstart_sig", 32'(sig4), 32'(exp_xor_sig));

    // Asynchronous reset at vector 9.
    pulse_start4();
    for (int j = 1; j <= 18; j++) tick();
    check("rst_vec9", 32'(dut_in4), 32'd9);
    #2;
    rst = 1'b1;
    #1;
    check_reset4("async_rst");
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (done4) done_seen++;
    end
    check("rst_no_done", 32'(done_seen), 32'd0);
    check("rst_idle_busy", 32'(busy4), 32'd0);
    pulse_start4();
    check("post_rst_vec0", 32'(dut_in4), 32'd0);
    wait_done(1'b0, 100, edges);
    check("post_rst_latency", 32'(edges), 32'd32);
    check("post_rst_table", 32'(table4), 32'h6996);

    // start held high: back-to-back sweeps every 33 edges.
    start4 = 1'b1;
    tick();
    wait_done(1'b0, 100, edges);
    check("b2b_first_latency", 32'(edges), 32'd32);
    check("b2b_first_table", 32'(table4), 32'h6996);
    and_mode = 1'b1;
    wait_done(1'b0, 100, edges);
    check("b2b_interval", 32'(edges), 32'd33);
    start4 = 1'b0;
    check("b2b_second_table", 32'(table4), 32'h8000);
    check("b2b_second_sig", 32'(sig4), 32'(exp_and_sig));
    // Third sweep begins on the done-cycle edge; its start-edge clears are visible here.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("b2b_clear_table", 32'(table4), 32'd0);
    check("b2b_clear_sig", 32'(sig4), 32'hFFFF);
    check("b2b_clear_busy", 32'(busy4), 32'd1);
    wait_done(1'b0, 100, edges);
    check("b2b_third_latency", 32'(edges), 32'd32);
    check("b2b_third_table", 32'(table4), 32'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
